// File: rtl/split_sample_driver_if.sv
// Request/result bundle between a split_sample_driver and its requester/split.
// The slave side is the driver itself; the master side issues requests and evaluates the split.
interface split_sample_driver_if #(
    parameter int VEC_W = 64
);
    logic             start;
    logic             seed_load;
    logic [31:0]      seed_in;
    logic [VEC_W-1:0] cand_o;
    logic             x_i;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic             sat;
    logic [7:0]       tries;

    modport master (
        output start, seed_load, seed_in, x_i, out_ready,
        input  cand_o, busy, out_valid, sat, tries
    );

    modport slave (
        input  start, seed_load, seed_in, x_i, out_ready,
        output cand_o, busy, out_valid, sat, tries
    );
endinterface

// File: rtl/split_sample_driver.sv
// LFSR-based candidate generator for a split_N constraint: fills the flattened
// assignment vector, waits for the split verdict and retries up to MAX_TRIES times.
module split_sample_driver #(
    parameter int          VEC_W     = 64,
    parameter int          EVAL_LAT  = 1,
    parameter int          MAX_TRIES = 16,
    parameter logic [31:0] SEED      = 32'hACE1_0001
) (
    input logic                  clk,
    input logic                  rst,
    split_sample_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, EVAL, HOLD} state_t;

    localparam int              WORDS     = (VEC_W + 31) / 32;
    localparam int              WC_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int              EC_W      = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORDS - 1);
    localparam logic [EC_W-1:0] EVAL_LAST = EC_W'(EVAL_LAT - 1);
    localparam logic [7:0]      TRY_LIMIT = 8'(MAX_TRIES);
    localparam logic [31:0]     TAPS      = 32'h8020_0003;

    state_t          state;
    logic [31:0]     lfsr;
    logic [31:0]     lfsr_next;
    logic [WC_W-1:0] word_cnt;
    logic [EC_W-1:0] eval_cnt;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
    endfunction

    assign lfsr_next = lfsr_step(lfsr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= SEED;
            word_cnt      <= '0;
            eval_cnt      <= '0;
            bus.cand_o    <= '0;
            bus.tries     <= '0;
            bus.sat       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero seed would lock the LFSR, so it falls back to SEED.
                    if (bus.seed_load) begin
                        lfsr <= (bus.seed_in == 32'h0) ? SEED : bus.seed_in;
                    end else if (bus.start) begin
                        bus.tries <= '0;
                        word_cnt  <= '0;
                        bus.busy  <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    // Earlier words migrate upward so the first word ends in the MSBs.
                    bus.cand_o <= VEC_W'({bus.cand_o, lfsr_next});
                    lfsr       <= lfsr_next;
                    if (word_cnt == WORD_LAST) begin
                        bus.tries <= bus.tries + 8'd1;
                        eval_cnt  <= '0;
                        state     <= EVAL;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (eval_cnt == EVAL_LAST) begin
                        if (bus.x_i) begin
                            bus.sat       <= 1'b1;
                            bus.out_valid <= 1'b1;
                            state         <= HOLD;
                        end else if (bus.tries == TRY_LIMIT) begin
                            bus.sat       <= 1'b0;
                            bus.out_valid <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            word_cnt <= '0;
                            state    <= FILL;
                        end
                    end else begin
                        eval_cnt <= eval_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_split_sample_driver.sv
// Directed bench for split_sample_driver: three instances cover the default
// geometry, a short retry budget and an odd vector width with longer evaluation latency.
module tb_split_sample_driver;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic clk;
    logic rst;
    logic a_cond;
    int   checks;
    int   failures;

    split_sample_driver_if #(.VEC_W(64)) bus_a ();
    split_sample_driver_if #(.VEC_W(64)) bus_b ();
    split_sample_driver_if #(.VEC_W(40)) bus_c ();

    split_sample_driver #(.VEC_W(64), .EVAL_LAT(1), .MAX_TRIES(16), .SEED(SEED))
        u_a (.clk(clk), .rst(rst), .bus(bus_a));
    split_sample_driver #(.VEC_W(64), .EVAL_LAT(1), .MAX_TRIES(4), .SEED(SEED))
        u_b (.clk(clk), .rst(rst), .bus(bus_b));
    split_sample_driver #(.VEC_W(40), .EVAL_LAT(3), .MAX_TRIES(16), .SEED(SEED))
        u_c (.clk(clk), .rst(rst), .bus(bus_c));

    assign bus_a.x_i = a_cond ? (bus_a.cand_o[3:0] == 4'hA) : 1'b1;
    assign bus_b.x_i = 1'b0;
    assign bus_c.x_i = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] lfsr_n(input logic [31:0] s, input int n);
        logic [31:0] v = s;
        for (int i = 0; i < n; i++) v = lfsr_step(v);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!bus_a.out_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic release_a();
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m, w1, w2, s;
        logic [63:0] snap_cand;
        logic [7:0]  snap_tries;
        logic        snap_sat, rdy, hit;
        int          n, t;

        checks = 0; failures = 0; a_cond = 1'b0;
        rst = 1'b1;
        bus_a.start = 0; bus_a.seed_load = 0; bus_a.seed_in = 0; bus_a.out_ready = 0;
        bus_b.start = 0; bus_b.seed_load = 0; bus_b.seed_in = 0; bus_b.out_ready = 0;
        bus_c.start = 0; bus_c.seed_load = 0; bus_c.seed_in = 0; bus_c.out_ready = 0;
        tick(); tick();
        chk("rst_cand", bus_a.cand_o, 64'h0);
        chk("rst_tries", bus_a.tries, 0);
        chk("rst_sat", bus_a.sat, 0);
        chk("rst_valid", bus_a.out_valid, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_lfsr", u_a.lfsr, SEED);
        rst = 1'b0;
        tick();

        // First-try success; start held high through FILL/EVAL/HOLD must not re-trigger.
        bus_a.start = 1'b1;
        tick();
        chk("ft_busy_rise", bus_a.busy, 1);
        chk("ft_valid_e1", bus_a.out_valid, 0);
        tick(); tick();
        chk("ft_valid_e2", bus_a.out_valid, 0);
        tick();
        chk("ft_valid_e3", bus_a.out_valid, 1);
        chk("ft_sat", bus_a.sat, 1);
        chk("ft_tries", bus_a.tries, 1);
        chk("ft_cand", bus_a.cand_o, {lfsr_n(SEED, 1), lfsr_n(SEED, 2)});
        tick();
        bus_a.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ft_stall_valid", bus_a.out_valid, 1);
            chk("ft_stall_tries", bus_a.tries, 1);
            chk("ft_stall_cand", bus_a.cand_o, {lfsr_n(SEED, 1), lfsr_n(SEED, 2)});
        end
        release_a();
        chk("ft_valid_fall", bus_a.out_valid, 0);
        chk("ft_busy_fall", bus_a.busy, 0);
        tick();
        chk("ft_no_second", bus_a.busy, 0);

        // Budget exhaustion on the MAX_TRIES=4 instance.
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        n = 0;
        while (!bus_b.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bud_latency", n, 12);
        chk("bud_sat", bus_b.sat, 0);
        chk("bud_tries", bus_b.tries, 4);
        chk("bud_cand", bus_b.cand_o, {lfsr_n(SEED, 7), lfsr_n(SEED, 8)});
        chk("bud_lfsr", u_b.lfsr, lfsr_n(SEED, 8));
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
        chk("bud_release", bus_b.out_valid, 0);

        // Odd width: VEC_W=40, EVAL_LAT=3.
        bus_c.start = 1'b1;
        tick();
        bus_c.start = 1'b0;
        n = 0;
        while (!bus_c.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("odd_latency", n, 5);
        chk("odd_sat", bus_c.sat, 1);
        chk("odd_tries", bus_c.tries, 1);
        chk("odd_cand", bus_c.cand_o, 40'({lfsr_n(SEED, 1), lfsr_n(SEED, 2)}));
        bus_c.out_ready = 1'b1;
        tick();
        bus_c.out_ready = 1'b0;
        chk("odd_release", bus_c.out_valid, 0);

        // Seed handling.
        bus_a.seed_in = 32'h0;
        bus_a.seed_load = 1'b1;
        tick();
        bus_a.seed_load = 1'b0;
        chk("seed_zero", u_a.lfsr, SEED);
        s = 32'h1234_5678;
        bus_a.seed_in = s;
        bus_a.seed_load = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.seed_load = 1'b0;
        bus_a.start = 1'b0;
        chk("seed_prio_busy", bus_a.busy, 0);
        chk("seed_load_val", u_a.lfsr, s);
        tick();
        chk("seed_prio_idle", bus_a.busy, 0);
        pulse_start_a();
        wait_a(n);
        chk("seed_latency", n, 3);
        chk("seed_cand", bus_a.cand_o, {lfsr_n(s, 1), lfsr_n(s, 2)});
        chk("seed_tries", bus_a.tries, 1);
        release_a();
        m = lfsr_n(s, 2);

        // Conditional accept with random backpressure.
        a_cond = 1'b1;
        for (int r = 0; r < 200; r++) begin
            t = 0; hit = 1'b0; w1 = '0; w2 = '0;
            while (!hit && t < 16) begin
                t++;
                w1 = lfsr_step(m);
                w2 = lfsr_step(w1);
                m = w2;
                hit = (w2[3:0] == 4'hA);
            end
            pulse_start_a();
            wait_a(n);
            chk("cond_latency", n, 3 * t);
            chk("cond_sat", bus_a.sat, hit);
            chk("cond_tries", bus_a.tries, t);
            chk("cond_cand", bus_a.cand_o, {w1, w2});
            snap_cand = bus_a.cand_o; snap_tries = bus_a.tries; snap_sat = bus_a.sat;
            for (int k = 0; k < 8; k++) begin
                rdy = (k == 7) ? 1'b1 : 1'($urandom_range(0, 1));
                bus_a.out_ready = rdy;
                tick();
                if (rdy) break;
                chk("cond_stall_valid", bus_a.out_valid, 1);
                chk("cond_stall_cand", bus_a.cand_o, snap_cand);
                chk("cond_stall_tries", bus_a.tries, snap_tries);
                chk("cond_stall_sat", bus_a.sat, snap_sat);
            end
            bus_a.out_ready = 1'b0;
            chk("cond_release", bus_a.out_valid, 0);
        end
        a_cond = 1'b0;

        // Reset during EVAL, then a fresh first-try request.
        pulse_start_a();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", bus_a.out_valid, 0);
        chk("mid_rst_busy", bus_a.busy, 0);
        chk("mid_rst_cand", bus_a.cand_o, 64'h0);
        chk("mid_rst_tries", bus_a.tries, 0);
        chk("mid_rst_sat", bus_a.sat, 0);
        chk("mid_rst_lfsr", u_a.lfsr, SEED);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_quiet", bus_a.out_valid, 0);
        end
        pulse_start_a();
        wait_a(n);
        chk("post_rst_latency", n, 3);
        chk("post_rst_sat", bus_a.sat, 1);
        chk("post_rst_tries", bus_a.tries, 1);
        chk("post_rst_cand", bus_a.cand_o, {lfsr_n(SEED, 1), lfsr_n(SEED, 2)});
        release_a();
        chk("post_rst_release", bus_a.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/split_sample_driver.md
# split_sample_driver

Sequential candidate-generation stage that sits directly upstream of a `split_N` constraint module. It fills a flattened assignment vector (the concatenation `var_0..var_K` that a split consumes) from a 32-bit LFSR and presents it to the split. It then samples the split's `x` result and retries until the candidate satisfies the constraint or a retry budget is exhausted. The outcome is returned on a valid/ready result port.

## Interface
Parameters:
- `VEC_W`, default 64: width of the flattened candidate vector, ≥1.
- `EVAL_LAT`, default 1: clocks between the candidate being stable and `x_i` being valid, ≥1.
- `MAX_TRIES`, default 16: candidates attempted per request, ≥1, ≤255.
- `SEED`, default 32'hACE1_0001: LFSR reset value, nonzero.
- Derived: `WORDS = ceil(VEC_W/32)`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a satisfying sample; honoured only in IDLE.
- `seed_load` in 1: load `seed_in` into the LFSR; honoured only in IDLE.
- `seed_in` in 32: new seed.
- `cand_o` out VEC_W: candidate vector driven to the split inputs; LSBs map to `var_0`.
- `x_i` in 1: split constraint result for `cand_o`.
- `busy` out 1: high in any state other than IDLE.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `sat` out 1: 1 means `cand_o` satisfies the split; 0 means the budget was exhausted.
- `tries` out 8: number of candidates evaluated for the current or last request.

## Operation
- States: IDLE, FILL, EVAL, HOLD.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps mask 32'h8020_0003). It advances exactly once per FILL cycle and holds in all other states.
- IDLE:
  - `seed_load` has priority over `start` in the same cycle. If both are high, the seed is loaded and `start` is ignored.
  - If `seed_in` is 0, the LFSR loads `SEED` instead, so it can never lock up at zero.
  - On `start`: `tries` ← 0, word counter ← 0, go to FILL.
- FILL, lasting WORDS cycles:
  - Each cycle: `cand_o` ← ({`cand_o`, lfsr} shifted left by 32 with lfsr in the LSBs), truncated to VEC_W; the LFSR advances.
  - After the WORDS-th load: `tries` ← `tries`+1, go to EVAL.
- EVAL, lasting EVAL_LAT cycles: `cand_o` is held stable. `x_i` is sampled only on the last EVAL cycle.
  - `x_i`=1: `sat` ← 1, go to HOLD.
  - `x_i`=0 and `tries`==MAX_TRIES: `sat` ← 0, go to HOLD.
  - Otherwise: go to FILL. `cand_o` keeps its old value until it is overwritten.
- HOLD:
  - `out_valid`=1.
  - `cand_o`, `sat` and `tries` are frozen.
  - On `out_valid & out_ready`: go to IDLE. `out_valid` falls on the next clock.
- `start` and `seed_load` outside IDLE are ignored and not queued.
- `out_ready` outside HOLD has no effect.

## Timing
- Reset values: state IDLE, `cand_o`=0, lfsr=`SEED`, `tries`=0, `sat`=0, `out_valid`=0, `busy`=0.
- Reset mid-operation aborts the request. No result is produced.
- Latency, measured from the edge that samples `start`:
  - `out_valid` is high after WORDS+EVAL_LAT edges when the first try succeeds.
  - Each failed try adds WORDS+EVAL_LAT edges.
  - Worst case is MAX_TRIES·(WORDS+EVAL_LAT).
- Throughput: a new `start` is accepted no earlier than the clock after the HOLD handshake.
- `x_i` must depend only on `cand_o`. It is never sampled in FILL, HOLD or IDLE.
- The consumer may hold `out_ready` low indefinitely. All outputs stay stable while `out_valid` is high.

## Test plan
- **First-try success.** `x_i` tied to 1, VEC_W=64, EVAL_LAT=1, `start` pulsed.
  - `busy` rises on the next edge.
  - `out_valid` is high 3 edges after start, with `sat`=1 and `tries`=1.
  - `cand_o` = {first LFSR word after SEED, second LFSR word}; check against a reference model.
- **Budget exhaustion.** `x_i` tied to 0, MAX_TRIES=4.
  - `out_valid` after 12 edges, `sat`=0, `tries`=4.
  - LFSR advanced exactly 8 times from SEED.
- **Conditional accept.** `x_i` = (`cand_o`[3:0]==4'hA).
  - Result has `sat`=1 and `cand_o`[3:0]=4'hA.
  - `tries` matches the model's first hit index.
  - Repeat for 200 requests with random `out_ready` backpressure. Outputs must stay stable while stalled.
- **Seed handling.**
  - `seed_load` with `seed_in`=0 loads SEED.
  - `seed_in`=32'h1234_5678 followed by `start` reproduces the model sequence.
  - `seed_load` and `start` in the same cycle: only the seed is loaded, `busy` stays 0.
- **Ignored requests and reset.**
  - `start` pulses during FILL, EVAL and HOLD cause no second request.
  - `rst` asserted during EVAL: the next cycle shows all reset values, `out_valid` never rises, and a subsequent `start` behaves like the first-try success scenario.
- **Odd width.** VEC_W=40, EVAL_LAT=3, `x_i`=1.
  - WORDS=2.
  - `cand_o` = low 40 bits of {w0,w1}.
  - `out_valid` after 5 edges.
